ending_sprite_anim: RTL and testbench
=====================================

// Module: ending_sprite_anim
// PURPOSE
//  Parametrised end-of-level sprite overlay. It runs a tick-driven FSM: hidden, drop-in, animate, blink, done.
//  Inputs are the VGA scan position and BG_step; it reads a 4-bit-indexed sprite sheet in a synchronous frame RAM.
//  It emits a per-pixel hit flag plus palette RGB to the colour mapper, with pipeline latency 2.
//  All logic runs on one clock; the slow rate is a tick-enable, not a derived clock.
// PARAMETERS
//  TICK_DIV     3_000_000  Clk cycles per animation tick (>=2)
//  SHOW_STEP    300        BG_step threshold that arms the sprite
//  X_HOME       305        screen X of sprite top-left
//  Y_HOME       243        final screen Y of sprite top-left
//  Y_START      0          screen Y at start of drop
//  Y_STEP       8          Y pixels per tick during drop (>=1)
//  SPR_W        13         source sprite width, sheet pixels
//  SPR_H        23         source sprite height, sheet pixels
//  SCALE_SHIFT  1          on-screen magnification = 1<<SCALE_SHIFT (0..2)
//  SHEET_W      188        sheet row pitch, pixels
//  ROM_X0       43         sheet X of frame 0
//  ROM_Y0       114        sheet Y of frames
//  NUM_FRAMES   2          animation frames (1..8), laid out horizontally
//  FRAME_STRIDE 13         sheet X distance between frames
//  HOLD_TICKS   10         ticks spent animating before blink
//  BLINK_TICKS  6          ticks of blink (visibility toggles each tick)
// PORTS
//  Clk        in   1   system clock
//  Reset      in   1   asynchronous, active-high reset
//  DrawX      in   10  current scan X
//  DrawY      in   10  current scan Y
//  BG_step    in   9   level scroll progress
//  rom_addr   out  19  frame-RAM read address (combinational from DrawX/DrawY)
//  rom_data   in   4   frame-RAM data, valid 1 Clk after rom_addr
//  is_ending  out  1   registered: sprite pixel opaque at this position
//  Red/Green/Blue out 8 each  registered colour, aligned with is_ending
//  done       out  1   registered: FSM in DONE
// BEHAVIOUR
//  Reset (async): state=IDLE, tick counter=0, Y_pos=Y_START, frame=0, tick-count=0, visible=0;
//   is_ending=0, RGB=0, done=0, hit pipeline cleared.
//  Tick: counter 0..TICK_DIV-1; tick=1 for one Clk when counter==TICK_DIV-1, then counter wraps to 0.
//  FSM advances only on tick cycles, except the disarm rule:
//   IDLE: visible=0; on tick with BG_step>=SHOW_STEP -> DROP with Y_pos=Y_START, visible=1.
//   DROP: each tick Y_pos=min(Y_pos+Y_STEP, Y_HOME), computed 11-bit with no wrap; on reaching Y_HOME -> HOLD, cnt=0.
//   HOLD: each tick frame=(frame+1) mod NUM_FRAMES, cnt++; when cnt reaches HOLD_TICKS -> BLINK, cnt=0.
//   BLINK: each tick visible toggles, cnt++; when cnt reaches BLINK_TICKS -> DONE with visible=1 forced.
//   DONE: frame frozen, visible=1, done=1; stays until disarm or reset.
//  Disarm: any Clk with BG_step<SHOW_STEP in any non-IDLE state -> IDLE next Clk, regardless of tick.
//   Y_pos/frame/cnt are reset as for Reset. Disarm has priority over any tick transition in the same cycle.
//  Hit (stage 0, combinational): visible && DrawX in [X_HOME, X_HOME+(SPR_W<<S)) && DrawY in [Y_pos, Y_pos+(SPR_H<<S)).
//  Address: dx=(DrawX-X_HOME)>>S, dy=(DrawY-Y_pos)>>S.
//   rom_addr = (ROM_X0+frame*FRAME_STRIDE+dx) + (ROM_Y0+dy)*SHEET_W, truncated to 19 bits; rom_addr=0 when no hit.
//  Stage 1: hit registered. Stage 2: colour and is_ending registered from hit_d1 and rom_data.
//   Latency DrawX/DrawY -> outputs = 2 Clk.
//  Palette (rom_data -> RGB), is_ending=hit_d1 && rom_data!=0:
//   0 transparent (RGB=0); 1 FFFDFB; 2 B53121; 3 F83800; 4 E18300; 5 1D7B01; 6 AC7C00; 7 D4E7C7; 8 057987;
//   9 000000; 10..15 FF00FF debug magenta, counted opaque.
//  No hit: is_ending=0, RGB=000000.
//  FSM state changes (Y_pos, frame, visible) take effect on hit from the Clk after the update.
//   Mid-scanline changes are permitted.
// TESTING (bench overrides TICK_DIV=4, Y_START=200, Y_STEP=20, HOLD_TICKS=3, BLINK_TICKS=2)
//  1 Reset asserted mid-DROP -> same Clk: is_ending=0, done=0. After release, BG_step=310: first tick -> DROP at Y=200.
//  2 BG_step=310, 4 Clk per tick -> Y_pos 200,220,240, then clamps at 243 (not 260); HOLD entered on that tick.
//  3 HOLD, NUM_FRAMES=2 -> frame 0,1,0 over 3 ticks; pixel (305,243) rom_addr = 43+13*frame+114*188.
//    Expected 21475 / 21488; outputs follow 2 Clk later.
//  4 BLINK -> is_ending at (305,243) toggles off/on per tick; after 2 ticks done=1 and sprite steady.
//  5 In DONE, BG_step drops to 100 on a tick cycle -> IDLE next Clk, done=0, is_ending=0; re-raise restarts DROP from 200.
//  6 rom_data: 0 -> is_ending=0; 3 -> F83800; 12 -> FF00FF; DrawX=304 or 331 (outside 305..330) -> is_ending=0.

Source files
------------

// File: rtl/ending_sprite_anim.sv
// End-of-level sprite overlay: the sprite drops in, animates, blinks, then stays on screen.
// A tick-enabled FSM drives a 2-stage pixel pipeline that reads a synchronous sprite-sheet RAM.
module ending_sprite_anim #(
  parameter int TICK_DIV     = 3_000_000,
  parameter int SHOW_STEP    = 300,
  parameter int X_HOME       = 305,
  parameter int Y_HOME       = 243,
  parameter int Y_START      = 0,
  parameter int Y_STEP       = 8,
  parameter int SPR_W        = 13,
  parameter int SPR_H        = 23,
  parameter int SCALE_SHIFT  = 1,
  parameter int SHEET_W      = 188,
  parameter int ROM_X0       = 43,
  parameter int ROM_Y0       = 114,
  parameter int NUM_FRAMES   = 2,
  parameter int FRAME_STRIDE = 13,
  parameter int HOLD_TICKS   = 10,
  parameter int BLINK_TICKS  = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [8:0]  BG_step,
  output logic [18:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        is_ending,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        done
);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [11:0] SPR_WS = 12'(SPR_W << SCALE_SHIFT);
  localparam logic [11:0] SPR_HS = 12'(SPR_H << SCALE_SHIFT);

  typedef enum logic [2:0] {S_IDLE, S_DROP, S_HOLD, S_BLINK, S_DONE} state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick_cnt;
  logic          tick, arm;
  logic [10:0]   y_pos, y_n;
  logic [11:0]   y_inc;
  logic [2:0]    frame, frame_n;
  logic [15:0]   cnt, cnt_n, cnt_inc;
  logic          visible, vis_n;
  logic [11:0]   rel_x, rel_y, dx, dy;
  logic          hit, hit_d1;

  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
  assign arm     = (int'(BG_step) >= SHOW_STEP);
  assign y_inc   = {1'b0, y_pos} + 12'(Y_STEP);
  assign cnt_inc = cnt + 16'd1;

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state   <= S_IDLE;
      y_pos   <= 11'(Y_START);
      frame   <= '0;
      cnt     <= '0;
      visible <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      y_pos   <= y_n;
      frame   <= frame_n;
      cnt     <= cnt_n;
      visible <= vis_n;
      done    <= (state_n == S_DONE);
    end

  // Disarm is checked every cycle and overrides any tick-driven step.
  always_comb begin
    state_n = state;
    y_n     = y_pos;
    frame_n = frame;
    cnt_n   = cnt;
    vis_n   = visible;
    if (state != S_IDLE && !arm) begin
      state_n = S_IDLE;
      y_n     = 11'(Y_START);
      frame_n = '0;
      cnt_n   = '0;
      vis_n   = 1'b0;
    end else if (tick) begin
      case (state)
        S_IDLE: if (arm) begin
          state_n = S_DROP;
          y_n     = 11'(Y_START);
          vis_n   = 1'b1;
        end
        S_DROP: if (y_inc >= 12'(Y_HOME)) begin
          y_n     = 11'(Y_HOME);
          state_n = S_HOLD;
          cnt_n   = '0;
        end else begin
          y_n = y_inc[10:0];
        end
        S_HOLD: begin
          frame_n = (frame == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame + 3'd1;
          if (cnt_inc == 16'(HOLD_TICKS)) begin
            state_n = S_BLINK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        S_BLINK: begin
          vis_n = !visible;
          if (cnt_inc == 16'(BLINK_TICKS)) begin
            state_n = S_DONE;
            vis_n   = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        S_DONE:  vis_n = 1'b1;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Stage 0: hit test and sheet address, widened to 12 bits so nothing wraps.
  always_comb begin
    rel_x = {2'b0, DrawX} - 12'(X_HOME);
    rel_y = {2'b0, DrawY} - {1'b0, y_pos};
    hit   = visible && ({2'b0, DrawX} >= 12'(X_HOME)) && (rel_x < SPR_WS)
                    && ({2'b0, DrawY} >= {1'b0, y_pos}) && (rel_y < SPR_HS);
    dx    = rel_x >> SCALE_SHIFT;
    dy    = rel_y >> SCALE_SHIFT;
    rom_addr = hit ? (19'(ROM_X0) + 19'(frame) * 19'(FRAME_STRIDE) + 19'(dx)
                      + (19'(ROM_Y0) + 19'(dy)) * 19'(SHEET_W)) : '0;
  end

  function automatic logic [23:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    palette = 24'h000000;
      4'd1:    palette = 24'hFFFDFB;
      4'd2:    palette = 24'hB53121;
      4'd3:    palette = 24'hF83800;
      4'd4:    palette = 24'hE18300;
      4'd5:    palette = 24'h1D7B01;
      4'd6:    palette = 24'hAC7C00;
      4'd7:    palette = 24'hD4E7C7;
      4'd8:    palette = 24'h057987;
      4'd9:    palette = 24'h000000;
      default: palette = 24'hFF00FF;
    endcase
  endfunction

  // Stage 1 holds the hit while the RAM fetches; stage 2 joins it with rom_data.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      hit_d1             <= 1'b0;
      is_ending          <= 1'b0;
      {Red, Green, Blue} <= 24'h0;
    end else begin
      hit_d1             <= hit;
      is_ending          <= hit_d1 && (rom_data != 4'd0);
      {Red, Green, Blue} <= hit_d1 ? palette(rom_data) : 24'h0;
    end
endmodule

// File: tb/tb_ending_sprite_anim.sv
// Randomized bench for ending_sprite_anim against a tick-count based reference model.
module tb_ending_sprite_anim;
  localparam int TICK_DIV = 4, SHOW_STEP = 300, X_HOME = 305, Y_HOME = 243;
  localparam int Y_START = 200, Y_STEP = 20, SPR_W = 13, SPR_H = 23, SCALE_SHIFT = 1;
  localparam int SHEET_W = 188, ROM_X0 = 43, ROM_Y0 = 114, NUM_FRAMES = 2;
  localparam int FRAME_STRIDE = 13, HOLD_TICKS = 3, BLINK_TICKS = 2;
  localparam int N_DROP  = (Y_HOME - Y_START + Y_STEP - 1) / Y_STEP;
  localparam int N_BLINK = N_DROP + HOLD_TICKS;
  localparam int N_DONE  = N_BLINK + BLINK_TICKS;
  localparam int SW = SPR_W << SCALE_SHIFT;
  localparam int SH = SPR_H << SCALE_SHIFT;

  logic        Clk, Reset;
  logic [9:0]  DrawX, DrawY;
  logic [8:0]  BG_step;
  logic [18:0] rom_addr;
  logic [3:0]  rom_data;
  logic        is_ending, done;
  logic [7:0]  Red, Green, Blue;

  int checks, errors, rom_force;
  logic [3:0] ram_tab [0:1023];

  // Model: the whole animation is a function of "armed" and ticks elapsed since arming.
  logic        m_armed, e_h1, e_is;
  int          m_k, m_tc;
  logic [23:0] e_rgb;

  ending_sprite_anim #(
    .TICK_DIV(TICK_DIV), .SHOW_STEP(SHOW_STEP), .X_HOME(X_HOME), .Y_HOME(Y_HOME),
    .Y_START(Y_START), .Y_STEP(Y_STEP), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .SCALE_SHIFT(SCALE_SHIFT), .SHEET_W(SHEET_W), .ROM_X0(ROM_X0), .ROM_Y0(ROM_Y0),
    .NUM_FRAMES(NUM_FRAMES), .FRAME_STRIDE(FRAME_STRIDE), .HOLD_TICKS(HOLD_TICKS),
    .BLINK_TICKS(BLINK_TICKS)
  ) dut (
    .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .BG_step(BG_step),
    .rom_addr(rom_addr), .rom_data(rom_data), .is_ending(is_ending),
    .Red(Red), .Green(Green), .Blue(Blue), .done(done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) rom_data <= (rom_force >= 0) ? 4'(rom_force) : ram_tab[rom_addr[9:0]];

  function automatic int y_of();
    if (!m_armed) return Y_START;
    return (m_k < N_DROP) ? Y_START + Y_STEP * m_k : Y_HOME;
  endfunction

  function automatic int frame_of();
    if (!m_armed || m_k < N_DROP) return 0;
    return (m_k < N_BLINK) ? (m_k - N_DROP) % NUM_FRAMES : HOLD_TICKS % NUM_FRAMES;
  endfunction

  function automatic logic vis_of();
    if (!m_armed) return 1'b0;
    if (m_k < N_BLINK || m_k >= N_DONE) return 1'b1;
    return ((m_k - N_BLINK) % 2) == 0;
  endfunction

  function automatic logic done_of();
    return m_armed && m_k >= N_DONE;
  endfunction

  function automatic logic hit_of(int x, int y);
    int yy = y_of();
    return vis_of() && x >= X_HOME && x < X_HOME + SW && y >= yy && y < yy + SH;
  endfunction

  function automatic int exp_addr(int x, int y);
    if (!hit_of(x, y)) return 0;
    return (ROM_X0 + frame_of() * FRAME_STRIDE + ((x - X_HOME) >> SCALE_SHIFT)
            + (ROM_Y0 + ((y - y_of()) >> SCALE_SHIFT)) * SHEET_W) & 32'h7FFFF;
  endfunction

  function automatic logic [23:0] pal_of(logic [3:0] d);
    case (d)
      4'd0: return 24'h000000;  4'd1: return 24'hFFFDFB;  4'd2: return 24'hB53121;
      4'd3: return 24'hF83800;  4'd4: return 24'hE18300;  4'd5: return 24'h1D7B01;
      4'd6: return 24'hAC7C00;  4'd7: return 24'hD4E7C7;  4'd8: return 24'h057987;
      4'd9: return 24'h000000;  default: return 24'hFF00FF;
    endcase
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_armed <= 1'b0; m_k <= 0; m_tc <= 0;
      e_h1 <= 1'b0; e_is <= 1'b0; e_rgb <= 24'h0;
    end else begin
      m_tc <= (m_tc == TICK_DIV - 1) ? 0 : m_tc + 1;
      if (m_armed && int'(BG_step) < SHOW_STEP) m_armed <= 1'b0;
      else if (m_tc == TICK_DIV - 1) begin
        if (!m_armed) begin
          if (int'(BG_step) >= SHOW_STEP) begin m_armed <= 1'b1; m_k <= 0; end
        end else if (m_k < 1000) m_k <= m_k + 1;
      end
      e_h1  <= hit_of(int'(DrawX), int'(DrawY));
      e_is  <= e_h1 && rom_data != 4'd0;
      e_rgb <= e_h1 ? pal_of(rom_data) : 24'h0;
    end
  end

  task automatic drive_rand();
    int xx, yy;
    case ($urandom_range(0, 4))
      0: xx = X_HOME - 1;  1: xx = X_HOME;  2: xx = X_HOME + SW - 1;  3: xx = X_HOME + SW;
      default: xx = X_HOME - 4 + int'($urandom_range(0, SW + 8));
    endcase
    case ($urandom_range(0, 5))
      0: yy = y_of() - 1;  1: yy = y_of();  2: yy = y_of() + SH - 1;  3: yy = y_of() + SH;
      4: yy = int'($urandom_range(0, 1023));
      default: yy = y_of() - 4 + int'($urandom_range(0, SH + 8));
    endcase
    DrawX = 10'(xx);
    DrawY = 10'(yy);
  endtask

  task automatic test_reset();
    bit reached;
    Reset = 1'b1; BG_step = 9'd310; DrawX = 10'd305; DrawY = 10'd200; rom_force = 5;
    repeat (3) @(negedge Clk);
    checks++;
    if (is_ending !== 1'b0 || {Red, Green, Blue} !== 24'h0 || done !== 1'b0 || rom_addr !== 19'h0) begin
      errors++;
      $display("FAIL reset_state: is=%b rgb=%h done=%b addr=%0d, want all zero",
               is_ending, {Red, Green, Blue}, done, rom_addr);
    end
    Reset = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      @(negedge Clk);
      DrawY = 10'(y_of());
      reached = m_armed && m_k == 1 && e_is;
    end
    checks++;
    if (is_ending !== 1'b1) begin
      errors++; $display("FAIL mid_drop_visible: is_ending=%b want 1 (reached=%b)", is_ending, reached);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (is_ending !== 1'b0 || done !== 1'b0 || {Red, Green, Blue} !== 24'h0) begin
      errors++; $display("FAIL reset_async: is=%b done=%b rgb=%h want 0/0/0", is_ending, done, {Red, Green, Blue});
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_arm_drop();
    bit armed_seen = 1'b0;
    rom_force = -1; DrawX = 10'd305; DrawY = 10'd200;
    for (int c = 0; c < 3 * TICK_DIV && !armed_seen; c++) begin
      @(negedge Clk);
      armed_seen = m_armed;
    end
    checks++;
    if (!armed_seen || rom_addr !== 19'd21475) begin
      errors++; $display("FAIL drop_start_addr: addr=%0d want 21475 (armed=%b)", rom_addr, armed_seen);
    end
    DrawY = 10'd199; #1;
    checks++;
    if (rom_addr !== 19'd0) begin
      errors++; $display("FAIL drop_above_top: addr=%0d want 0", rom_addr);
    end
    for (int c = 0; c < 60 && m_k <= N_DROP; c++) begin
      @(negedge Clk);
      checks++;
      if (is_ending !== e_is || {Red, Green, Blue} !== e_rgb || done !== done_of()) begin
        errors++;
        $display("FAIL drop_pix c=%0d: is=%b rgb=%h done=%b want is=%b rgb=%h done=%b",
                 c, is_ending, {Red, Green, Blue}, done, e_is, e_rgb, done_of());
      end
      drive_rand(); #1;
      checks++;
      if (rom_addr !== 19'(exp_addr(int'(DrawX), int'(DrawY)))) begin
        errors++;
        $display("FAIL drop_addr (%0d,%0d) k=%0d: addr=%0d want %0d",
                 DrawX, DrawY, m_k, rom_addr, exp_addr(int'(DrawX), int'(DrawY)));
      end
    end
  endtask

  task automatic test_hold();
    rom_force = -1;
    for (int c = 0; c < 60 && m_k < N_BLINK; c++) begin
      @(negedge Clk);
      checks++;
      if (is_ending !== e_is || {Red, Green, Blue} !== e_rgb) begin
        errors++;
        $display("FAIL hold_pix c=%0d: is=%b rgb=%h want is=%b rgb=%h", c, is_ending, {Red, Green, Blue}, e_is, e_rgb);
      end
      DrawX = 10'd305; DrawY = 10'd243; #1;
      checks++;
      if (rom_addr !== ((frame_of() == 0) ? 19'd21475 : 19'd21488)) begin
        errors++; $display("FAIL hold_addr k=%0d frame=%0d: addr=%0d", m_k, frame_of(), rom_addr);
      end
    end
  endtask

  task automatic test_blink();
    bit saw_off = 1'b0;
    rom_force = 3; DrawX = 10'd305; DrawY = 10'd243;
    for (int c = 0; c < 60 && m_k <= N_DONE; c++) begin
      @(negedge Clk);
      checks++;
      if (is_ending !== e_is || {Red, Green, Blue} !== e_rgb || done !== done_of()) begin
        errors++;
        $display("FAIL blink_pix c=%0d: is=%b rgb=%h done=%b want is=%b rgb=%h done=%b",
                 c, is_ending, {Red, Green, Blue}, done, e_is, e_rgb, done_of());
      end
      if (is_ending === 1'b0) saw_off = 1'b1;
    end
    checks++;
    if (!saw_off || done !== 1'b1 || is_ending !== 1'b1 || {Red, Green, Blue} !== 24'hF83800) begin
      errors++;
      $display("FAIL blink_done: saw_off=%b done=%b is=%b rgb=%h want 1/1/1/F83800",
               saw_off, done, is_ending, {Red, Green, Blue});
    end
  endtask

  task automatic test_disarm();
    bit armed_seen = 1'b0;
    for (int c = 0; c < TICK_DIV + 1 && m_tc != TICK_DIV - 1; c++) @(negedge Clk);
    BG_step = 9'd100;
    @(negedge Clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL disarm_done: done=%b want 0", done);
    end
    repeat (2) @(negedge Clk);
    checks++;
    if (is_ending !== 1'b0 || {Red, Green, Blue} !== 24'h0) begin
      errors++; $display("FAIL disarm_pix: is=%b rgb=%h want 0/000000", is_ending, {Red, Green, Blue});
    end
    BG_step = 9'd310; DrawX = 10'd305; DrawY = 10'd200;
    for (int c = 0; c < 3 * TICK_DIV && !armed_seen; c++) begin
      @(negedge Clk);
      armed_seen = m_armed;
    end
    checks++;
    if (!armed_seen || rom_addr !== 19'd21475) begin
      errors++; $display("FAIL rearm_addr: addr=%0d want 21475 (armed=%b)", rom_addr, armed_seen);
    end
  endtask

  task automatic test_palette();
    int px [6] = '{305, 305, 305, 304, 331, 330};
    int pd [6] = '{0, 3, 12, 3, 3, 3};
    logic        wis [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [23:0] wrgb [6] = '{24'h0, 24'hF83800, 24'hFF00FF, 24'h0, 24'h0, 24'hF83800};
    DrawX = 10'd305; DrawY = 10'd250;
    for (int c = 0; c < 80 && !done_of(); c++) @(negedge Clk);
    for (int i = 0; i < 6; i++) begin
      DrawX = 10'(px[i]); DrawY = 10'd250; rom_force = pd[i];
      repeat (3) @(negedge Clk);
      checks++;
      if (is_ending !== wis[i] || {Red, Green, Blue} !== wrgb[i]) begin
        errors++;
        $display("FAIL palette x=%0d d=%0d: is=%b rgb=%h want is=%b rgb=%h",
                 px[i], pd[i], is_ending, {Red, Green, Blue}, wis[i], wrgb[i]);
      end
    end
  endtask

  task automatic test_random();
    rom_force = -1;
    for (int c = 0; c < 600; c++) begin
      @(negedge Clk);
      checks++;
      if (is_ending !== e_is || {Red, Green, Blue} !== e_rgb || done !== done_of()) begin
        errors++;
        $display("FAIL rand_pix c=%0d: is=%b rgb=%h done=%b want is=%b rgb=%h done=%b",
                 c, is_ending, {Red, Green, Blue}, done, e_is, e_rgb, done_of());
      end
      if (c % 16 == 0)
        BG_step = ($urandom_range(0, 5) == 0) ? 9'($urandom_range(0, SHOW_STEP - 1))
                                              : 9'($urandom_range(SHOW_STEP, 511));
      drive_rand(); #1;
      checks++;
      if (rom_addr !== 19'(exp_addr(int'(DrawX), int'(DrawY)))) begin
        errors++;
        $display("FAIL rand_addr (%0d,%0d) c=%0d: addr=%0d want %0d",
                 DrawX, DrawY, c, rom_addr, exp_addr(int'(DrawX), int'(DrawY)));
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; rom_force = 5;
    Reset = 1'b1; BG_step = '0; DrawX = '0; DrawY = '0; rom_data = '0;
    for (int i = 0; i < 1024; i++) ram_tab[i] = 4'($urandom_range(0, 15));
    test_reset();
    test_arm_drop();
    test_hold();
    test_blink();
    test_disarm();
    test_palette();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
